// File: rtl/clock_rate_pkg.sv
// Shared types and helpers for the runtime-configurable clock generator.
// Holds the FSM state encoding and the Hz-to-terminal-count conversion.
package clock_rate_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

    // Half-period terminal count for a target output frequency.
    function automatic int unsigned hz_to_div(input int unsigned hz,
                                              input int unsigned clk_hz = CLK_HZ_DEFAULT);
        return clk_hz / (2 * hz) - 1;
    endfunction

endpackage

// File: rtl/div_counter.sv
// Half-period counter: wraps to 0 when it reaches the terminal value.
// Latency: term_cnt is combinational from the counter flop; no backpressure.
// clear wins over run; with run low the count holds.
module div_counter #(
    parameter int unsigned DIV_W = 26
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] term_val,
    output logic [DIV_W-1:0] count,
    output logic             term_cnt
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign term_cnt = (cnt_q == term_val);
    assign count    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = term_cnt ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_rate_ctrl.sv
// Square-wave generator with glitch-free divisor changes and safe start/stop.
// Latency: first rise active_div+1 cycles after RUN; new divisor lands at a half-period boundary.
// Backpressure: cfg_ready drops while a divisor is pending and returns the cycle after it is applied.
module clock_rate_ctrl
    import clock_rate_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int unsigned DEFAULT_HZ = 60,
    parameter int unsigned DIV_W      = 26
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(hz_to_div(DEFAULT_HZ, CLK_HZ));

    state_t           state_q, state_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             cnt_run;
    logic             cnt_clear;
    logic [DIV_W-1:0] cnt;
    logic             term_cnt;
    logic             xfer;

    div_counter #(.DIV_W(DIV_W)) u_div_counter (
        .clk_in   (clk_in),
        .reset    (reset),
        .run      (cnt_run),
        .clear    (cnt_clear),
        .term_val (active_div_q),
        .count    (cnt),
        .term_cnt (term_cnt)
    );

    assign cfg_ready = ~pending_q;
    assign xfer      = cfg_valid & cfg_ready;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = (state_q != STOP);

    always_comb begin
        state_d      = state_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pending_d    = pending_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        cnt_run      = 1'b0;
        cnt_clear    = 1'b0;

        case (state_q)
            STOP: begin
                cnt_clear = 1'b1;
                clk_out_d = 1'b0;
                if (xfer) begin
                    active_div_d = cfg_div;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                cnt_run = 1'b1;
                if (state_q == RUN && !enable && !clk_out_q) begin
                    // Low phase can be cut short safely: output is already low.
                    state_d   = STOP;
                    cnt_clear = 1'b1;
                    clk_out_d = 1'b0;
                    if (pending_q) begin
                        active_div_d = pend_div_q;
                        pending_d    = 1'b0;
                    end else if (xfer) begin
                        active_div_d = cfg_div;
                    end
                end else begin
                    // Here clk_out is high whenever enable is low, so the high phase runs out.
                    if (enable) begin
                        state_d = RUN;
                    end else if (term_cnt) begin
                        state_d = STOP;
                    end else begin
                        state_d = DRAIN;
                    end
                    if (term_cnt) begin
                        clk_out_d = ~clk_out_q;
                        tick_d    = ~clk_out_q;
                        if (pending_q) begin
                            active_div_d = pend_div_q;
                            pending_d    = 1'b0;
                        end
                    end
                    if (xfer) begin
                        if (state_d == STOP) begin
                            active_div_d = cfg_div;
                        end else begin
                            pend_div_d = cfg_div;
                            pending_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = STOP;
                cnt_clear = 1'b1;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= STOP;
            active_div_q <= DEFAULT_DIV;
            pend_div_q   <= '0;
            pending_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    // Divisor only changes when the counter is at 0 or at the old terminal value.
    a_cnt_in_range: assert property (@(posedge clk_in) disable iff (reset) cnt <= active_div_q);

endmodule
